accum_alu: RTL and testbench
============================

ACCUM_ALU -- requirements
Module: accum_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port din  in  WIDTH  operand data.
REQ-005 The block SHALL have port load  in  1  single-cycle operand capture strobe.
REQ-006 The block SHALL have port sub  in  1  operation select, 0 = add, 1 = subtract; sampled together with operand B.
REQ-007 The block SHALL have port acc  in  1  accumulate select; sampled with load in DONE.
REQ-008 The block SHALL have port clear  in  1  synchronous return to IDLE.
REQ-009 The block SHALL have ports a_q and b_q  out  WIDTH  registered operands, for display.
REQ-010 The block SHALL have port sum  out  WIDTH  registered result.
REQ-011 The block SHALL have ports cout, ovf, valid  out  1 each  carry/no-borrow flag, signed-overflow flag and result-valid flag.
REQ-012 The block SHALL have port state  out  2  current FSM state encoding.

Function
REQ-013 The FSM SHALL have states IDLE=00, HAVE_A=01, CALC=10 and DONE=11.
REQ-014 In IDLE, load=1 SHALL set a_q<=din and move to HAVE_A; all other inputs are ignored.
REQ-015 In HAVE_A, load=1 SHALL set b_q<=din, latch sub, and move to CALC; without load the FSM holds.
REQ-016 CALC SHALL last exactly one cycle, ignore load, register sum/cout/ovf, set valid=1 and move to DONE; the result is visible one cycle after the B-capture edge.
REQ-017 In DONE with load=1 and acc=1, the block SHALL set a_q<=sum, b_q<=din, latch sub and go to CALC, keeping valid=1 and the old result until the new one is registered.
REQ-018 In DONE with load=1 and acc=0, the block SHALL set a_q<=din, valid<=0 and go to HAVE_A.
REQ-019 In DONE without load, all outputs SHALL hold.
REQ-020 clear=1 SHALL take priority over load in every state: next state IDLE, a_q/b_q/sum/cout/ovf/valid all zero.
REQ-021 Add SHALL compute {cout,sum} = a_q + b_q at WIDTH+1 bits, i.e. wrap modulo 2^WIDTH.
REQ-022 Subtract SHALL compute a_q + ~b_q + 1; cout=1 means no borrow (a_q >= b_q unsigned).
REQ-023 ovf SHALL be 1 when the two's-complement signed result overflows: operands of equal sign (after b_q inversion for subtract) and result sign differing.

Reset
REQ-024 On rst_n=0, the block SHALL immediately, independent of clk, set state=IDLE and drive a_q, b_q, sum, cout, ovf and valid to 0.
REQ-025 Reset asserted mid-CALC or mid-accumulate SHALL discard the operation; the first load after release SHALL be captured as A.

Configuration
REQ-026 When ACCUM_ALU_SAT_EN is defined, a result with ovf=1 SHALL saturate sum to 0111..1 (positive overflow) or 1000..0 (negative overflow), with ovf still reported and cout unchanged.
REQ-027 When ACCUM_ALU_SAT_EN is not defined, sum SHALL wrap modulo 2^WIDTH.

Verification (WIDTH=8)
REQ-028 Scenario: load 0x3C, then load 0x14 with sub=0 -> next cycle sum=0x50, cout=0, ovf=0, valid=1, state=DONE.
REQ-029 Scenario: 0xFF + 0x01 -> sum=0x00, cout=1, ovf=0; then 0x7F + 0x01 -> sum=0x80 and ovf=1 (sum=0x7F with ACCUM_ALU_SAT_EN).
REQ-030 Scenario: 0x10 - 0x20 (sub=1) -> sum=0xF0, cout=0, ovf=0; 0x20 - 0x10 -> sum=0x10, cout=1.
REQ-031 Scenario: 0x05 + 0x03, then in DONE load 0x02 with acc=1 -> a_q=0x08 and sum=0x0A; then load 0x09 with acc=0 -> valid=0, a_q=0x09, state=HAVE_A.
REQ-032 Scenario: rst_n pulsed low during CALC -> all outputs 0 and state=IDLE without a clock edge; clear and load asserted in the same cycle in HAVE_A -> IDLE and b_q=0.

Source files
------------

// File: rtl/accum_alu.sv
// accum_alu: two-operand add/subtract sequencer with accumulate chaining, Rev 1.0
// Build option ACCUM_ALU_SAT_EN: saturate the signed result on overflow instead of wrapping.
`default_nettype none

module accum_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             sub,
  input  logic             acc,
  input  logic             clear,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             valid,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HAVE_A = 2'b01,
    CALC   = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] a_d, b_d, sum_d;
  logic             cout_d, ovf_d, valid_d;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sum_raw;
  logic [WIDTH-1:0] sum_res;
  logic             ovf_raw;

  // Subtract is a + ~b + 1, so the carry-in is simply the latched op bit.
  assign b_eff    = sub_q ? ~b_q : b_q;
  assign add_full = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_q};
  assign sum_raw  = add_full[WIDTH-1:0];
  assign ovf_raw  = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum_raw[WIDTH-1] != a_q[WIDTH-1]);

`ifdef ACCUM_ALU_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // A wrapped negative-looking result means the true value overflowed positive.
  assign sum_res = ovf_raw ? (sum_raw[WIDTH-1] ? SAT_MAX : SAT_MIN) : sum_raw;
`else
  assign sum_res = sum_raw;
`endif

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum     <= sum_d;
      cout    <= cout_d;
      ovf     <= ovf_d;
      valid   <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum;
    cout_d  = cout;
    ovf_d   = ovf;
    valid_d = valid;

    if (clear) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      sub_d   = 1'b0;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            a_d     = din;
            state_d = HAVE_A;
          end
        end
        HAVE_A: begin
          if (load) begin
            b_d     = din;
            sub_d   = sub;
            state_d = CALC;
          end
        end
        CALC: begin
          sum_d   = sum_res;
          cout_d  = add_full[WIDTH];
          ovf_d   = ovf_raw;
          valid_d = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          if (load) begin
            if (acc) begin
              // Chain: previous result becomes A; old result stays valid until replaced.
              a_d     = sum;
              b_d     = din;
              sub_d   = sub;
              state_d = CALC;
            end else begin
              a_d     = din;
              valid_d = 1'b0;
              state_d = HAVE_A;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_accum_alu.sv
// tb_accum_alu: directed vector table plus hand sequences for accumulate, reset and clear.
`default_nettype none

module tb_accum_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       load;
  logic       sub;
  logic       acc;
  logic       clear;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       valid;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  accum_alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .load  (load),
    .sub   (sub),
    .acc   (acc),
    .clear (clear),
    .a_q   (a_q),
    .b_q   (b_q),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .valid (valid),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       op_sub;
    logic [7:0] exp_wrap;
    logic [7:0] exp_sat;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vt [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    //           a      b      sub   wrap   sat    cout  ovf
    vt[0] = '{8'h3C, 8'h14, 1'b0, 8'h50, 8'h50, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
    vt[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 8'hF0, 1'b0, 1'b0};
    vt[4] = '{8'h20, 8'h10, 1'b1, 8'h10, 8'h10, 1'b1, 1'b0};
    vt[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
    vt[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
    vt[7] = '{8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[8] = '{8'h64, 8'h64, 1'b0, 8'hC8, 8'h7F, 1'b0, 1'b1};

    rst_n = 1'b0;
    din   = 8'h00;
    load  = 1'b0;
    sub   = 1'b0;
    acc   = 1'b0;
    clear = 1'b0;

    #2;
    chk("rst_state", 0, state, 2'b00);
    chk("rst_a", 0, a_q, 8'h00);
    chk("rst_b", 0, b_q, 8'h00);
    chk("rst_sum", 0, sum, 8'h00);
    chk("rst_flags", 0, {cout, ovf, valid}, 3'b000);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_state", i, state, 2'b00);
      load = 1'b1;
      din  = vt[i].a;
      tick();
      chk("a_state", i, state, 2'b01);
      chk("a_q", i, a_q, vt[i].a);
      din = vt[i].b;
      sub = vt[i].op_sub;
      tick();
      load = 1'b0;
      sub  = ~vt[i].op_sub;
      din  = 8'hA5;
      chk("b_state", i, state, 2'b10);
      chk("b_q", i, b_q, vt[i].b);
      chk("b_valid", i, valid, 1'b0);
      tick();
`ifdef ACCUM_ALU_SAT_EN
      chk("sum", i, sum, vt[i].exp_sat);
`else
      chk("sum", i, sum, vt[i].exp_wrap);
`endif
      chk("cout", i, cout, vt[i].exp_cout);
      chk("ovf", i, ovf, vt[i].exp_ovf);
      chk("valid", i, valid, 1'b1);
      chk("done_state", i, state, 2'b11);
      sub = 1'b0;
    end

    // 05 + 03 with load held into CALC, then accumulate 02, then restart with 09.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    load  = 1'b1;
    din   = 8'h05;
    tick();
    din = 8'h03;
    tick();
    chk("acc_calc", 0, state, 2'b10);
    din = 8'h40;
    tick();
    load = 1'b0;
    chk("calc_ign_b", 0, b_q, 8'h03);
    chk("calc_ign_a", 0, a_q, 8'h05);
    chk("acc_sum0", 0, sum, 8'h08);
    tick();
    chk("hold_sum", 0, sum, 8'h08);
    chk("hold_state", 0, state, 2'b11);
    chk("hold_valid", 0, valid, 1'b1);
    load = 1'b1;
    acc  = 1'b1;
    din  = 8'h02;
    tick();
    load = 1'b0;
    acc  = 1'b0;
    chk("acc_state", 0, state, 2'b10);
    chk("acc_a", 0, a_q, 8'h08);
    chk("acc_b", 0, b_q, 8'h02);
    chk("acc_keep_valid", 0, valid, 1'b1);
    chk("acc_keep_sum", 0, sum, 8'h08);
    tick();
    chk("acc_sum1", 0, sum, 8'h0A);
    chk("acc_done", 0, state, 2'b11);
    load = 1'b1;
    din  = 8'h09;
    tick();
    chk("new_valid", 0, valid, 1'b0);
    chk("new_a", 0, a_q, 8'h09);
    chk("new_state", 0, state, 2'b01);

    // Async reset while in CALC with a nonzero old result still held.
    din = 8'h01;
    tick();
    load = 1'b0;
    chk("pre_rst_state", 0, state, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("arst_state", 0, state, 2'b00);
    chk("arst_a", 0, a_q, 8'h00);
    chk("arst_b", 0, b_q, 8'h00);
    chk("arst_sum", 0, sum, 8'h00);
    chk("arst_flags", 0, {cout, ovf, valid}, 3'b000);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 0, state, 2'b00);
    load = 1'b1;
    din  = 8'h11;
    tick();
    chk("post_rst_state", 0, state, 2'b01);
    chk("post_rst_a", 0, a_q, 8'h11);

    // clear beats load in HAVE_A.
    clear = 1'b1;
    din   = 8'h33;
    tick();
    clear = 1'b0;
    load  = 1'b0;
    chk("clr_ld_state", 0, state, 2'b00);
    chk("clr_ld_b", 0, b_q, 8'h00);
    chk("clr_ld_a", 0, a_q, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
